seq_multiplier: RTL and testbench



---
 rtl/multiplier_pkg.sv | 15 +
 rtl/seq_multiplier_datapath.sv | 62 ++++++
 rtl/seq_multiplier.sv | 109 ++++++++++
 tb/tb_seq_multiplier.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DONE    = 2'd2
    } mult_state_t;

    // Step counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Datapath: accumulator A, multiplier/low-product Q, multiplicand M and mode bit.
// One shift-and-add step per do_shift; the last signed step subtracts because
// the multiplier MSB carries negative weight in two's complement.
module seq_multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_do_init,
    input  logic                 i_do_shift,
    input  logic                 i_do_clear,
    input  logic                 i_last_step,
    input  logic                 i_is_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_sgn;

    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic             w_fill;

    // Add/subtract selection and arithmetic fill bit for the right shift.
    always_comb begin
        w_addend = r_sgn ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_sum    = r_a;
        if (r_q[0]) begin
            w_sum = (r_sgn && i_last_step) ? (r_a - w_addend) : (r_a + w_addend);
        end
        w_fill = r_sgn & w_sum[WIDTH];
    end

    // Operand capture, per-step shift, and abort clear of the product registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_sgn <= 1'b0;
        end else if (i_do_clear) begin
            r_a <= '0;
            r_q <= '0;
        end else if (i_do_init) begin
            r_a   <= '0;
            r_q   <= i_multiplier;
            r_m   <= i_multiplicand;
            r_sgn <= i_is_signed;
        end else if (i_do_shift) begin
            {r_a, r_q} <= {w_fill, w_sum, r_q[WIDTH-1:1]};
        end
    end

    assign o_product = {r_a[WIDTH-1:0], r_q};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement signed.
// Level start/ready handshake; abort cancels from any state.
//
// state   | meaning
// IDLE    | waiting for start; product holds last result (or 0)
// WORKING | one shift-add step per cycle, WIDTH steps total
// DONE    | ready=1; wait for start to drop before returning to IDLE
module seq_multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);

    mult_state_t     r_state;
    mult_state_t     w_next;
    logic [CW-1:0]   r_count;
    logic            w_do_init;
    logic            w_do_shift;
    logic            w_do_clear;
    logic            w_last_step;

    assign w_last_step = (r_count == '0);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath controls; abort overrides everything.
    always_comb begin
        w_next     = r_state;
        w_do_init  = 1'b0;
        w_do_shift = 1'b0;
        w_do_clear = 1'b0;
        if (abort) begin
            w_next     = IDLE;
            w_do_clear = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_do_init = 1'b1;
                        w_next    = WORKING;
                    end
                end
                WORKING: begin
                    w_do_shift = 1'b1;
                    if (w_last_step) begin
                        w_next = DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Step down-counter; terminal count marks the final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_do_init) begin
            r_count <= CNT_INIT;
        end else if (w_do_shift && !w_last_step) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign ready = (r_state == DONE);
    assign busy  = (r_state == WORKING);

    seq_multiplier_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_do_init      (w_do_init),
        .i_do_shift     (w_do_shift),
        .i_do_clear     (w_do_clear),
        .i_last_step    (w_last_step),
        .i_is_signed    (is_signed),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_product      (product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases at WIDTH=8, randomized ops checked
// against an arithmetic reference model, plus random sweeps at WIDTH=4 and 16.
module tb_seq_multiplier;

    localparam int W = 8;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            rst_aux_n = 1'b0;
    logic            start = 1'b0;
    logic            is_signed = 1'b0;
    logic            abort = 1'b0;
    logic [W-1:0]    mcand = '0;
    logic [W-1:0]    mplier = '0;
    logic            ready;
    logic            busy;
    logic [2*W-1:0]  product;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seq_multiplier #(.WIDTH(W)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .abort        (abort),
        .ready        (ready),
        .busy         (busy),
        .product      (product)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit sg,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sg) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Transaction-level model: what busy/ready/product must be after each edge.
    bit              m_busy  = 1'b0;
    bit              m_ready = 1'b0;
    logic [2*W-1:0]  m_prod  = '0;
    logic [2*W-1:0]  m_res   = '0;
    int              m_left  = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_prod  = '0;
            m_left  = 0;
        end else if (abort) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_prod  = '0;
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
                m_prod  = m_res;
            end else begin
                m_left--;
            end
        end else if (m_ready) begin
            if (!start) m_ready = 1'b0;
        end else if (start) begin
            m_busy = 1'b1;
            m_left = W - 1;
            m_res  = (2*W)'(ref_mul(W, is_signed, 32'(mcand), 32'(mplier)));
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("busy", 64'(busy), 64'(m_busy));
            check("ready", 64'(ready), 64'(m_ready));
            if (!m_busy) check("product", 64'(product), 64'(m_prod));
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit sg, input bit hold);
        @(posedge clock);
        #1;
        mcand     = a;
        mplier    = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = hold;
    endtask

    task automatic wait_done(input bit scr, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = int'(busy);
        while (cyc < 4 * W) begin
            @(posedge clock);
            #1;
            cyc++;
            bcnt += int'(busy);
            if (ready) break;
            if (scr) begin
                is_signed = 1'($urandom);
                mcand     = W'($urandom);
                mplier    = W'($urandom);
            end
        end
        if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    endtask

    // Random sweeps at other widths on their own reset.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 4 : 16;
        logic             s_start = 1'b0;
        logic             s_sgn = 1'b0;
        logic [SW-1:0]    s_a = '0;
        logic [SW-1:0]    s_b = '0;
        logic             s_busy;
        logic             s_ready;
        logic [2*SW-1:0]  s_prod;
        bit               done = 1'b0;

        seq_multiplier #(.WIDTH(SW)) u_dut_sw (
            .clock        (clock),
            .reset_n      (rst_aux_n),
            .start        (s_start),
            .is_signed    (s_sgn),
            .multiplicand (s_a),
            .multiplier   (s_b),
            .abort        (1'b0),
            .ready        (s_ready),
            .busy         (s_busy),
            .product      (s_prod)
        );

        initial begin
            int k;
            @(posedge rst_aux_n);
            repeat (2) @(posedge clock);
            for (int n = 0; n < 40; n++) begin
                @(posedge clock);
                #1;
                s_a     = SW'($urandom);
                s_b     = SW'($urandom);
                s_sgn   = 1'($urandom);
                if (n < 4) begin
                    s_a = {1'b1, {(SW-1){1'b0}}};
                    s_b = (n[0]) ? {SW{1'b1}} : {1'b1, {(SW-1){1'b0}}};
                    s_sgn = n[1];
                end
                s_start = 1'b1;
                @(posedge clock);
                #1;
                s_start = 1'b0;
                k = 0;
                while (!s_ready && k < 4 * SW) begin
                    @(posedge clock);
                    #1;
                    k++;
                end
                check($sformatf("w%0d_latency", SW), 64'(k), 64'(SW));
                check($sformatf("w%0d_prod", SW), 64'(s_prod),
                      ref_mul(SW, s_sgn, 32'(s_a), 32'(s_b)));
            end
            done = 1'b1;
        end
    end

    initial begin
        int cyc, bcnt, lim;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        #20;
        reset_n   = 1'b1;
        rst_aux_n = 1'b1;

        // Unsigned 255 x 255: latency, busy width, result.
        start_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        wait_done(1'b0, cyc, bcnt);
        check("u255_latency", 64'(cyc), 64'd8);
        check("u255_busy_cycles", 64'(bcnt), 64'd8);
        check("u255_prod", 64'(product), 64'hFE01);

        // Signed literal cases.
        start_op(8'hFD, 8'h05, 1'b1, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("s_m3x5", 64'(product), 64'hFFF1);
        start_op(8'h80, 8'h80, 1'b1, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("s_m128xm128", 64'(product), 64'h4000);
        start_op(8'h7F, 8'h80, 1'b1, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("s_127xm128", 64'(product), 64'hC080);
        start_op(8'h00, 8'hFF, 1'b1, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("s_0xm1", 64'(product), 64'h0000);

        // Mode matters at the start edge only.
        start_op(8'h80, 8'h02, 1'b0, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("u_80x02", 64'(product), 64'h0100);
        start_op(8'h80, 8'h02, 1'b1, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("s_80x02", 64'(product), 64'hFF00);
        start_op(8'h80, 8'h02, 1'b1, 1'b0); wait_done(1'b1, cyc, bcnt);
        check("s_80x02_scrambled", 64'(product), 64'hFF00);

        // Abort during the fourth WORKING cycle, then a fresh start.
        start_op(8'd200, 8'd99, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(ready), 64'd0);
        check("abort_prod", 64'(product), 64'd0);
        start_op(8'd12, 8'd11, 1'b0, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("after_abort_prod", 64'(product), 64'h0084);

        // Abort on the same edge as the final step.
        start_op(8'd9, 8'd9, 1'b0, 1'b0);
        repeat (7) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_last_ready", 64'(ready), 64'd0);
        check("abort_last_prod", 64'(product), 64'd0);

        // Abort beats start in IDLE.
        @(posedge clock);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start", 64'(busy), 64'd0);

        // Held start: no retrigger, restart after one low cycle.
        start_op(8'd3, 8'd4, 1'b0, 1'b1);
        wait_done(1'b0, cyc, bcnt);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("hold_ready", 64'(ready), 64'd1);
            check("hold_busy", 64'(busy), 64'd0);
        end
        check("hold_prod", 64'(product), 64'd12);
        start = 1'b0;
        @(posedge clock);
        #1;
        check("hold_drop_ready", 64'(ready), 64'd0);
        mcand  = 8'd5;
        mplier = 8'd5;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(1'b0, cyc, bcnt);
        check("restart_prod", 64'(product), 64'd25);

        // Asynchronous reset between edges during WORKING.
        start_op(8'd77, 8'd55, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_prod", 64'(product), 64'd0);
        #3;
        reset_n = 1'b1;
        start_op(8'd7, 8'd6, 1'b0, 1'b0); wait_done(1'b0, cyc, bcnt);
        check("after_rst_prod", 64'(product), 64'h002A);

        // Random ops at WIDTH=8, both modes, inputs scrambled while WORKING.
        for (int n = 0; n < 30; n++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            wait_done(1'b1, cyc, bcnt);
        end

        lim = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && lim < 5000) begin
            @(posedge clock);
            lim++;
        end
        check("sweep_finished", 64'(g_sweep[0].done && g_sweep[1].done), 64'd1);

        @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
